// File: rtl/gbe_rx_drain_master.sv
// Wishbone master that drains packets from the GbE RX buffer onto a valid/ready stream.
// Polls the sizes register, reads each word, presents it, then releases the buffer.
module gbe_rx_drain_master #(
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter logic [15:0] POLL_INTERVAL = 16'd256,
    parameter logic [15:0] ACK_TIMEOUT   = 16'd1024,
    parameter logic [12:0] MAX_BYTES     = 13'd2048
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        enable,
    output logic [31:0] rx_data,
    output logic [3:0]  rx_keep,
    output logic        rx_valid,
    output logic        rx_last,
    input  logic        rx_ready,
    output logic [15:0] pkt_count,
    output logic        bus_error,
    output logic        oversize
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL,
        S_READ,
        S_OUT,
        S_CLEAR
    } state_t;

    state_t      r_state, w_state;
    logic [15:0] r_poll_cnt, w_poll_cnt;
    logic [15:0] r_to_cnt, w_to_cnt;
    logic        r_cyc, w_cyc;
    logic        r_we, w_we;
    logic [31:0] r_adr, w_adr;
    logic [31:0] r_dat, w_dat;
    logic [3:0]  r_sel, w_sel;
    logic [12:0] r_bytes, w_bytes;
    logic [13:0] r_words, w_words;
    logic [13:0] r_idx, w_idx;
    logic [31:0] r_rx_data, w_rx_data;
    logic [3:0]  r_rx_keep, w_rx_keep;
    logic        r_rx_valid, w_rx_valid;
    logic        r_rx_last, w_rx_last;
    logic [15:0] r_pkt_count, w_pkt_count;
    logic        r_bus_error, w_bus_error;
    logic        r_oversize, w_oversize;

    logic [12:0] w_size_raw;
    logic        w_over;
    logic [12:0] w_size_eff;
    logic [13:0] w_words_calc;
    logic        w_fail;
    logic        w_is_last;
    logic [3:0]  w_last_keep;
    logic [31:0] w_sizes_adr;
    logic [31:0] w_word_adr;

    assign w_size_raw   = wb_dat_i[12:0];
    assign w_over       = (w_size_raw > MAX_BYTES);
    assign w_size_eff   = w_over ? MAX_BYTES : w_size_raw;
    assign w_words_calc = ({1'b0, w_size_eff} + 14'd3) >> 2;
    assign w_sizes_adr  = BASE_ADDR + 32'h0000_0018;
    assign w_word_adr   = BASE_ADDR + 32'h0000_2000 + {16'd0, r_idx, 2'b00};
    assign w_is_last    = (r_idx == (r_words - 14'd1));

    // A timeout fires on the last cycle of the allowed window if no ack has arrived.
    assign w_fail = r_cyc & (wb_err_i | (~wb_ack_i & (r_to_cnt == (ACK_TIMEOUT - 16'd1))));

    always_comb begin
        unique case (r_bytes[1:0])
            2'd1:    w_last_keep = 4'b1000;
            2'd2:    w_last_keep = 4'b1100;
            2'd3:    w_last_keep = 4'b1110;
            default: w_last_keep = 4'b1111;
        endcase
    end

    always_comb begin
        w_state     = r_state;
        w_poll_cnt  = r_poll_cnt;
        w_to_cnt    = r_cyc ? (r_to_cnt + 16'd1) : 16'd0;
        w_cyc       = r_cyc;
        w_we        = r_we;
        w_adr       = r_adr;
        w_dat       = r_dat;
        w_sel       = r_sel;
        w_bytes     = r_bytes;
        w_words     = r_words;
        w_idx       = r_idx;
        w_rx_data   = r_rx_data;
        w_rx_keep   = r_rx_keep;
        w_rx_valid  = r_rx_valid;
        w_rx_last   = r_rx_last;
        w_pkt_count = r_pkt_count;
        w_bus_error = r_bus_error;
        w_oversize  = r_oversize;

        if (w_fail) begin
            w_cyc       = 1'b0;
            w_we        = 1'b0;
            w_bus_error = 1'b1;
            w_poll_cnt  = POLL_INTERVAL;
            w_state     = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        if (r_poll_cnt == 16'd0) begin
                            w_state = S_POLL;
                        end else begin
                            w_poll_cnt = r_poll_cnt - 16'd1;
                        end
                    end
                end
                S_POLL: begin
                    if (!r_cyc) begin
                        w_cyc = 1'b1;
                        w_we  = 1'b0;
                        w_adr = w_sizes_adr;
                        w_dat = 32'd0;
                        w_sel = 4'hF;
                    end else if (wb_ack_i) begin
                        w_cyc = 1'b0;
                        if (w_size_raw == 13'd0) begin
                            w_poll_cnt = POLL_INTERVAL;
                            w_state    = S_IDLE;
                        end else begin
                            w_bytes = w_size_eff;
                            w_words = w_words_calc;
                            w_idx   = 14'd0;
                            if (w_over) begin
                                w_oversize = 1'b1;
                            end
                            w_state = S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (!r_cyc) begin
                        w_cyc = 1'b1;
                        w_we  = 1'b0;
                        w_adr = w_word_adr;
                        w_dat = 32'd0;
                        w_sel = 4'hF;
                    end else if (wb_ack_i) begin
                        w_cyc      = 1'b0;
                        w_rx_data  = wb_dat_i;
                        w_rx_valid = 1'b1;
                        w_rx_last  = w_is_last;
                        w_rx_keep  = w_is_last ? w_last_keep : 4'hF;
                        w_state    = S_OUT;
                    end
                end
                S_OUT: begin
                    if (rx_ready) begin
                        w_rx_valid = 1'b0;
                        w_rx_last  = 1'b0;
                        if ((r_idx + 14'd1) == r_words) begin
                            w_state = S_CLEAR;
                        end else begin
                            w_idx   = r_idx + 14'd1;
                            w_state = S_READ;
                        end
                    end
                end
                S_CLEAR: begin
                    if (!r_cyc) begin
                        w_cyc = 1'b1;
                        w_we  = 1'b1;
                        w_adr = w_sizes_adr;
                        w_dat = 32'd0;
                        w_sel = 4'b0001;
                    end else if (wb_ack_i) begin
                        w_cyc       = 1'b0;
                        w_we        = 1'b0;
                        w_pkt_count = r_pkt_count + 16'd1;
                        w_poll_cnt  = POLL_INTERVAL;
                        w_state     = S_IDLE;
                    end
                end
                default: begin
                    w_state = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= S_IDLE;
            r_poll_cnt  <= POLL_INTERVAL;
            r_to_cnt    <= 16'd0;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= 32'd0;
            r_dat       <= 32'd0;
            r_sel       <= 4'd0;
            r_bytes     <= 13'd0;
            r_words     <= 14'd0;
            r_idx       <= 14'd0;
            r_rx_data   <= 32'd0;
            r_rx_keep   <= 4'd0;
            r_rx_valid  <= 1'b0;
            r_rx_last   <= 1'b0;
            r_pkt_count <= 16'd0;
            r_bus_error <= 1'b0;
            r_oversize  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_poll_cnt  <= w_poll_cnt;
            r_to_cnt    <= w_to_cnt;
            r_cyc       <= w_cyc;
            r_we        <= w_we;
            r_adr       <= w_adr;
            r_dat       <= w_dat;
            r_sel       <= w_sel;
            r_bytes     <= w_bytes;
            r_words     <= w_words;
            r_idx       <= w_idx;
            r_rx_data   <= w_rx_data;
            r_rx_keep   <= w_rx_keep;
            r_rx_valid  <= w_rx_valid;
            r_rx_last   <= w_rx_last;
            r_pkt_count <= w_pkt_count;
            r_bus_error <= w_bus_error;
            r_oversize  <= w_oversize;
        end
    end

    assign wb_cyc_o  = r_cyc;
    assign wb_stb_o  = r_cyc;
    assign wb_we_o   = r_we;
    assign wb_adr_o  = r_adr;
    assign wb_dat_o  = r_dat;
    assign wb_sel_o  = r_sel;
    assign rx_data   = r_rx_data;
    assign rx_keep   = r_rx_keep;
    assign rx_valid  = r_rx_valid;
    assign rx_last   = r_rx_last;
    assign pkt_count = r_pkt_count;
    assign bus_error = r_bus_error;
    assign oversize  = r_oversize;

endmodule
